pipe_barrel_shifter: RTL and testbench
======================================

// Module: pipe_barrel_shifter
// PURPOSE
//   Multi-mode, pipelined barrel shifter: SRL, SRA, SLL, ROR on an IWIDTH-bit word.
//   Valid/ready streaming handshake on input and output.
//   Sits between the register-file read port and the ALU result mux.
//   Replaces the single-mode combinational right shifter at full clock rate.
// PARAMETERS
//   IWIDTH  32               data width; must be a power of two >= 2
//   SWIDTH  $clog2(IWIDTH)   shift-amount width = number of stages (5 at default)
// PORTS
//   CLK        in   1       rising-edge clock
//   RST_N      in   1       asynchronous active-low reset
//   IN_VALID   in   1       input operation valid
//   IN_READY   out  1       block can accept an operation this cycle
//   MODE       in   2       00 SRL, 01 SRA, 10 SLL, 11 ROR (rotate right)
//   BS_AMT     in   SWIDTH  shift amount, 0..IWIDTH-1
//   D_IN       in   IWIDTH  operand
//   OUT_VALID  out  1       D_OUT holds a completed result
//   OUT_READY  in   1       consumer takes D_OUT this cycle
//   D_OUT      out  IWIDTH  shifted result
//   BUSY       out  1       any stage holds a valid operation
// BEHAVIOUR
//   - Reset (RST_N=0, async): all stage valid bits, OUT_VALID and BUSY = 0.
//     D_OUT and all stage data registers = 0. Reset mid-stream discards every in-flight op.
//   - Pipeline: SWIDTH stages, MSB first. Stage k applies shift 2^(SWIDTH-1-k) when BS_AMT bit
//     (SWIDTH-1-k) is set, then registers. Default order is 16, 8, 4, 2, 1.
//     Each stage register carries {valid, mode, amt, data}.
//   - Latency: result appears on D_OUT exactly SWIDTH cycles after acceptance.
//     This holds when there is no backpressure. Throughput is 1 op/cycle.
//   - Transfer occurs when VALID & READY are both 1 at a CLK edge.
//   - Bubble-collapsing flow control: stage k may load iff it is empty or stage k+1 loads.
//     The last stage may load iff it is empty or OUT_READY=1.
//   - IN_READY = stage-0 load enable. It is combinational from OUT_READY through the chain.
//   - Full pipe with OUT_READY=1 accepts a new op and emits one in the same cycle.
//   - Full pipe with OUT_READY=0: IN_READY=0. Data is held. OUT_VALID stays 1 with D_OUT stable.
//   - Ordering is strictly FIFO. No op is dropped or duplicated.
//   - Fill rules:
//     - SRL: zero fill from the MSB side.
//     - SRA: fill with D_IN[IWIDTH-1].
//     - SLL: zero fill from the LSB side.
//     - ROR: bits leaving the LSB re-enter at the MSB.
//   - BS_AMT=0 gives D_OUT=D_IN for every mode.
//   - BS_AMT is taken modulo IWIDTH by construction.
//   - MODE, BS_AMT and D_IN are sampled only on an input transfer. At other times they are don't-care.
//   - BUSY = OR of all stage valid bits.
// STRUCTURE
//   - define.h holds IWIDTH and SWIDTH defaults, plus mode codes `BS_SRL/`BS_SRA/`BS_SLL/`BS_ROR.
//   - Sub-module bs_stage (params IWIDTH, SHIFT): one shift step plus its register slice with
//     valid/load logic.
//   - The top instantiates SWIDTH copies in a generate loop and wires the ready chain.
// TESTING
//   1. SRL D_IN=32'h8000_0000 AMT=31, OUT_READY=1 -> D_OUT=32'h0000_0001, 5 cycles after accept.
//   2. SRA 32'h8000_0000 AMT=4 -> 32'hF800_0000. SLL 32'h0000_0001 AMT=31 -> 32'h8000_0000.
//   3. ROR 32'h1234_5678 AMT=8 -> 32'h7812_3456. Any mode with AMT=0 -> operand unchanged.
//   4. Stream 8 ops back-to-back; drop OUT_READY for 4 cycles from cycle 3.
//      -> IN_READY falls once all 5 stages are full; D_OUT is held stable.
//      -> All 8 results emerge in order, none lost or repeated.
//   5. Assert RST_N low with 3 ops in flight.
//      -> OUT_VALID/BUSY go 0 immediately (async).
//      -> No stale result appears after release; the first new op has normal 5-cycle latency.
//   6. 10k random ops with random OUT_READY/IN_VALID vs a behavioural model -> zero mismatches.
//      Repeat with IWIDTH=16 (SWIDTH=4).

Source files
------------

// File: rtl/pipe_barrel_shifter_pkg.sv
// Shared widths and operation codes for the pipelined barrel shifter.
package pipe_barrel_shifter_pkg;

    localparam int unsigned BS_IWIDTH = 32;
    localparam int unsigned BS_SWIDTH = $clog2(BS_IWIDTH);

    typedef enum logic [1:0] {
        BS_SRL = 2'b00,
        BS_SRA = 2'b01,
        BS_SLL = 2'b10,
        BS_ROR = 2'b11
    } bs_mode_e;

endpackage

// File: rtl/pipe_barrel_shifter_bs_stage.sv
// One barrel-shifter step (fixed SHIFT, gated by one amount bit) plus its register slice.
module bs_stage
    import pipe_barrel_shifter_pkg::*;
#(
    parameter int unsigned IWIDTH = BS_IWIDTH,
    parameter int unsigned SWIDTH = $clog2(IWIDTH),
    parameter int unsigned SHIFT  = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              load,
    input  logic              in_valid,
    input  bs_mode_e          in_mode,
    input  logic [SWIDTH-1:0] in_amt,
    input  logic [IWIDTH-1:0] in_data,
    output logic              out_valid,
    output bs_mode_e          out_mode,
    output logic [SWIDTH-1:0] out_amt,
    output logic [IWIDTH-1:0] out_data
);

    localparam int unsigned AMT_BIT = $clog2(SHIFT);

    logic [IWIDTH-1:0] shifted;

    always_comb begin
        shifted = in_data;
        if (in_amt[AMT_BIT]) begin
            case (in_mode)
                BS_SRL:  shifted = in_data >> SHIFT;
                BS_SRA:  shifted = $signed(in_data) >>> SHIFT;
                BS_SLL:  shifted = in_data << SHIFT;
                BS_ROR:  shifted = (in_data >> SHIFT) | (in_data << (IWIDTH - SHIFT));
                default: shifted = in_data;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid <= 1'b0;
            out_mode  <= BS_SRL;
            out_amt   <= '0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= in_valid;
            out_mode  <= in_mode;
            out_amt   <= in_amt;
            out_data  <= shifted;
        end
    end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined SRL/SRA/SLL/ROR barrel shifter, one stage per shift-amount bit, MSB first,
// with bubble-collapsing valid/ready flow control.
module pipe_barrel_shifter
    import pipe_barrel_shifter_pkg::*;
#(
    parameter int unsigned IWIDTH = BS_IWIDTH,
    parameter int unsigned SWIDTH = $clog2(IWIDTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [1:0]        MODE,
    input  logic [SWIDTH-1:0] BS_AMT,
    input  logic [IWIDTH-1:0] D_IN,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [IWIDTH-1:0] D_OUT,
    output logic              BUSY
);

    // Index 0 is the input port; index k+1 is the register of stage k.
    logic              s_valid [SWIDTH+1];
    bs_mode_e          s_mode  [SWIDTH+1];
    logic [SWIDTH-1:0] s_amt   [SWIDTH+1];
    logic [IWIDTH-1:0] s_data  [SWIDTH+1];
    logic [SWIDTH:0]   load;

    assign s_valid[0] = IN_VALID;
    assign s_mode[0]  = bs_mode_e'(MODE);
    assign s_amt[0]   = BS_AMT;
    assign s_data[0]  = D_IN;

    // Ready chain resolved in one block, from the output back to stage 0.
    always_comb begin
        load         = '0;
        load[SWIDTH] = OUT_READY;
        for (int unsigned k = SWIDTH; k > 0; k--) begin
            load[k-1] = !s_valid[k] || load[k];
        end
    end

    for (genvar k = 0; k < SWIDTH; k++) begin : g_stage
        bs_stage #(
            .IWIDTH (IWIDTH),
            .SWIDTH (SWIDTH),
            .SHIFT  (1 << (SWIDTH - 1 - k))
        ) u_stage (
            .CLK       (CLK),
            .RST_N     (RST_N),
            .load      (load[k]),
            .in_valid  (s_valid[k]),
            .in_mode   (s_mode[k]),
            .in_amt    (s_amt[k]),
            .in_data   (s_data[k]),
            .out_valid (s_valid[k+1]),
            .out_mode  (s_mode[k+1]),
            .out_amt   (s_amt[k+1]),
            .out_data  (s_data[k+1])
        );
    end

    always_comb begin
        BUSY = 1'b0;
        for (int unsigned k = 1; k <= SWIDTH; k++) begin
            BUSY = BUSY | s_valid[k];
        end
    end

    assign IN_READY  = load[0];
    assign OUT_VALID = s_valid[SWIDTH];
    assign D_OUT     = s_data[SWIDTH];

    // Mode/amount of the final slice have no consumer downstream.
    logic unused_tail;
    assign unused_tail = ^{s_mode[SWIDTH], s_amt[SWIDTH]};

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Directed and randomized checks of pipe_barrel_shifter against a bit-level reference model.
module tb_pipe_barrel_shifter;

    localparam int unsigned IW = 32;
    localparam int unsigned SW = 5;
    localparam logic [1:0] M_SRL = 2'b00;
    localparam logic [1:0] M_SRA = 2'b01;
    localparam logic [1:0] M_SLL = 2'b10;
    localparam logic [1:0] M_ROR = 2'b11;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [1:0]    MODE = 2'b00;
    logic [SW-1:0] BS_AMT = '0;
    logic [IW-1:0] D_IN = '0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic [IW-1:0] D_OUT;
    logic          BUSY;

    int n_checks = 0;
    int n_errors = 0;
    int n_out = 0;
    logic [IW-1:0] exp_q[$];
    logic          hold_prev = 1'b0;
    logic [IW-1:0] hold_data = '0;

    pipe_barrel_shifter #(.IWIDTH(IW), .SWIDTH(SW)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .MODE      (MODE),
        .BS_AMT    (BS_AMT),
        .D_IN      (D_IN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .D_OUT     (D_OUT),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] ref_shift(input logic [1:0] m, input logic [SW-1:0] a,
                                                input logic [IW-1:0] d);
        logic [IW-1:0] r;
        int src;
        r = '0;
        for (int i = 0; i < int'(IW); i++) begin
            case (m)
                M_SRL: begin
                    src = i + int'(a);
                    if (src < int'(IW)) r[i] = d[src];
                    else r[i] = 1'b0;
                end
                M_SRA: begin
                    src = i + int'(a);
                    if (src < int'(IW)) r[i] = d[src];
                    else r[i] = d[IW-1];
                end
                M_SLL: begin
                    src = i - int'(a);
                    if (src >= 0) r[i] = d[src];
                    else r[i] = 1'b0;
                end
                default: begin
                    src = (i + int'(a)) % int'(IW);
                    r[i] = d[src];
                end
            endcase
        end
        return r;
    endfunction

    // Scoreboard: transfers are observed mid-cycle, where inputs are stable.
    always @(negedge CLK) begin
        if (!RST_N) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", {31'd0, OUT_VALID}, 32'd1);
                check("hold_data", D_OUT, hold_data);
            end
            if (OUT_VALID && OUT_READY) begin
                n_out++;
                if (exp_q.size() == 0) check("spurious_out", exp_q.size(), 1);
                else check("order_data", D_OUT, exp_q.pop_front());
            end
            if (IN_VALID && IN_READY) exp_q.push_back(ref_shift(MODE, BS_AMT, D_IN));
            hold_prev = OUT_VALID && !OUT_READY;
            hold_data = D_OUT;
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Issue one op into an empty pipe; latency counts the accepting edge as cycle 1.
    task automatic send_and_check(input string tag, input logic [1:0] m, input logic [SW-1:0] a,
                                  input logic [IW-1:0] d, input logic [IW-1:0] exp);
        logic acc;
        int lat;
        acc = 1'b0;
        IN_VALID = 1'b1;
        MODE = m;
        BS_AMT = a;
        D_IN = d;
        OUT_READY = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge CLK);
            acc = IN_READY;
            cyc();
        end
        check({tag, "_accept"}, {31'd0, acc}, 32'd1);
        IN_VALID = 1'b0;
        lat = 1;
        while (!OUT_VALID && lat < 20) begin
            cyc();
            lat++;
        end
        check({tag, "_latency"}, lat, SW);
        check(tag, D_OUT, exp);
        cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    t_mode [8];
        logic [SW-1:0] t_amt  [8];
        logic [IW-1:0] t_data [8];
        int idx;
        int n_before;
        int acc_cnt;
        logic acc;

        // Reset state
        #1;
        check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_d_out", D_OUT, 32'h0);
        check("rst_in_ready", {31'd0, IN_READY}, 32'd1);
        cyc();
        cyc();
        RST_N = 1'b1;
        cyc();

        // Directed modes and boundaries
        send_and_check("srl_31", M_SRL, 5'd31, 32'h8000_0000, 32'h0000_0001);
        send_and_check("sra_neg4", M_SRA, 5'd4, 32'h8000_0000, 32'hF800_0000);
        send_and_check("sra_pos4", M_SRA, 5'd4, 32'h7000_0000, 32'h0700_0000);
        send_and_check("sll_31", M_SLL, 5'd31, 32'h0000_0001, 32'h8000_0000);
        send_and_check("ror_8", M_ROR, 5'd8, 32'h1234_5678, 32'h7812_3456);
        send_and_check("ror_1", M_ROR, 5'd1, 32'h0000_0001, 32'h8000_0000);
        send_and_check("srl_16", M_SRL, 5'd16, 32'hF000_000F, 32'h0000_F000);
        send_and_check("srl_0", M_SRL, 5'd0, 32'hA5A5_0F0F, 32'hA5A5_0F0F);
        send_and_check("sra_0", M_SRA, 5'd0, 32'hA5A5_0F0F, 32'hA5A5_0F0F);
        send_and_check("sll_0", M_SLL, 5'd0, 32'hA5A5_0F0F, 32'hA5A5_0F0F);
        send_and_check("ror_0", M_ROR, 5'd0, 32'hA5A5_0F0F, 32'hA5A5_0F0F);
        check("idle_busy", {31'd0, BUSY}, 32'd0);

        // Eight back-to-back ops, consumer stalls for cycles 3..6
        for (int i = 0; i < 8; i++) begin
            t_mode[i] = 2'(i);
            t_amt[i]  = 5'(3 * i + 1);
            t_data[i] = 32'hC0DE_0000 + 32'(i * 32'h1111);
        end
        idx = 0;
        n_before = n_out;
        for (int c = 0; c < 40 && (idx < 8 || exp_q.size() != 0); c++) begin
            OUT_READY = !(c >= 3 && c < 7);
            IN_VALID = (idx < 8);
            if (idx < 8) begin
                MODE = t_mode[idx];
                BS_AMT = t_amt[idx];
                D_IN = t_data[idx];
            end
            @(negedge CLK);
            acc = IN_VALID && IN_READY;
            if (c == 3) check("bubble_ready", {31'd0, IN_READY}, 32'd1);
            if (c == 5 || c == 6) begin
                check("full_stall_ready", {31'd0, IN_READY}, 32'd0);
                check("full_stall_accepted", idx, 5);
            end
            if (c == 7) check("resume_ready", {31'd0, IN_READY}, 32'd1);
            cyc();
            if (acc) idx++;
        end
        IN_VALID = 1'b0;
        check("stream_accepted", idx, 8);
        check("stream_emitted", n_out - n_before, 8);
        check("stream_drained", exp_q.size(), 0);
        cyc();

        // Reset with three ops in flight
        OUT_READY = 1'b0;
        for (int c = 0; c < 5; c++) begin
            IN_VALID = (c % 2 == 0);
            MODE = M_SLL;
            BS_AMT = 5'(c + 1);
            D_IN = 32'(c + 1);
            cyc();
        end
        IN_VALID = 1'b0;
        check("pre_rst_out_valid", {31'd0, OUT_VALID}, 32'd1);
        check("pre_rst_busy", {31'd0, BUSY}, 32'd1);
        RST_N = 1'b0;
        #1;
        check("async_rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("async_rst_busy", {31'd0, BUSY}, 32'd0);
        check("async_rst_d_out", D_OUT, 32'h0);
        @(negedge CLK);
        #2;
        RST_N = 1'b1;
        n_before = n_out;
        OUT_READY = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        check("no_stale_out", n_out, n_before);
        check("post_rst_busy", {31'd0, BUSY}, 32'd0);
        send_and_check("post_rst_ror", M_ROR, 5'd4, 32'h0000_00AB, 32'hB000_000A);

        // Random traffic against the scoreboard
        acc_cnt = 0;
        for (int c = 0; c < 20000 && acc_cnt < 2000; c++) begin
            IN_VALID = ($urandom_range(0, 3) != 0);
            MODE = 2'($urandom);
            BS_AMT = 5'($urandom);
            D_IN = $urandom;
            OUT_READY = ($urandom_range(0, 2) != 0);
            @(negedge CLK);
            if (IN_VALID && IN_READY) acc_cnt++;
            cyc();
        end
        check("rand_accepted", acc_cnt, 2000);
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || BUSY); i++) cyc();
        check("rand_drained", exp_q.size(), 0);
        check("rand_busy", {31'd0, BUSY}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
